// File: rtl/sram_line_bridge.sv
// Line-to-word SRAM bridge: serializes one wide line read or write into
// consecutive single-word accesses on the external memory bus.
module sram_line_bridge #(
    parameter int ADDR_SIZE_BITS  = 24,
    parameter int WORD_SIZE_BYTES = 3,
    parameter int DATA_SIZE_WORDS = 64
) (
    input  logic                                         clk,
    input  logic                                         n_rst,
    input  logic                                         read_enable,
    input  logic                                         write_enable,
    input  logic [ADDR_SIZE_BITS-1:0]                    address,
    input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] write_data,
    output logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] read_data,
    output logic                                         read_valid,
    output logic                                         write_done,
    output logic                                         busy,
    output logic [ADDR_SIZE_BITS-1:0]                    mem_addr,
    output logic                                         mem_re,
    output logic                                         mem_we,
    output logic [WORD_SIZE_BYTES*8-1:0]                 mem_wdata,
    input  logic [WORD_SIZE_BYTES*8-1:0]                 mem_rdata
);

    localparam int WORD_W = WORD_SIZE_BYTES * 8;
    localparam int LINE_W = WORD_W * DATA_SIZE_WORDS;
    localparam int IDX_W  = $clog2(DATA_SIZE_WORDS);
    localparam int CNT_W  = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_SIZE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_LAST,
        RD_DONE,
        WR,
        WR_DONE
    } state_t;

    state_t                    r_state;
    logic [ADDR_SIZE_BITS-1:0] r_base;
    logic [LINE_W-1:0]         r_wline;
    logic [LINE_W-1:0]         r_rline;
    logic [CNT_W-1:0]          r_cnt;
    logic [ADDR_SIZE_BITS-1:0] r_mem_addr;
    logic [WORD_W-1:0]         r_mem_wdata;
    logic                      r_mem_re;
    logic                      r_mem_we;
    logic                      r_read_valid;
    logic                      r_write_done;
    logic                      r_busy;

    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [IDX_W-1:0]          w_slot;
    logic [IDX_W-1:0]          w_slot_nxt;
    logic [ADDR_SIZE_BITS-1:0] w_addr_nxt;
    logic [WORD_W-1:0]         w_wword_nxt;

    // r_cnt is the index currently on the bus; captures land one slot behind it
    assign w_cnt_nxt   = r_cnt + CNT_W'(1);
    assign w_slot      = IDX_W'(r_cnt - CNT_W'(1));
    assign w_slot_nxt  = IDX_W'(w_cnt_nxt);
    assign w_addr_nxt  = r_base + ADDR_SIZE_BITS'(w_cnt_nxt);
    assign w_wword_nxt = r_wline[w_slot_nxt*WORD_W +: WORD_W];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_base       <= '0;
            r_wline      <= '0;
            r_rline      <= '0;
            r_cnt        <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_read_valid <= 1'b0;
            r_write_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (write_enable) begin
                        r_base      <= address;
                        r_wline     <= write_data;
                        r_cnt       <= '0;
                        r_state     <= WR;
                        r_busy      <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= address;
                        r_mem_wdata <= write_data[WORD_W-1:0];
                    end else if (read_enable) begin
                        r_base     <= address;
                        r_cnt      <= '0;
                        r_state    <= RD;
                        r_busy     <= 1'b1;
                        r_mem_re   <= 1'b1;
                        r_mem_addr <= address;
                    end
                end
                RD: begin
                    if (r_cnt != '0) begin
                        r_rline[w_slot*WORD_W +: WORD_W] <= mem_rdata;
                    end
                    r_cnt <= w_cnt_nxt;
                    if (r_cnt == LAST_CNT) begin
                        r_state    <= RD_LAST;
                        r_mem_re   <= 1'b0;
                        r_mem_addr <= '0;
                    end else begin
                        r_mem_addr <= w_addr_nxt;
                    end
                end
                RD_LAST: begin
                    r_rline[w_slot*WORD_W +: WORD_W] <= mem_rdata;
                    r_state      <= RD_DONE;
                    r_read_valid <= 1'b1;
                end
                RD_DONE: begin
                    r_read_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                WR: begin
                    r_cnt <= w_cnt_nxt;
                    if (r_cnt == LAST_CNT) begin
                        r_state      <= WR_DONE;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= '0;
                        r_mem_wdata  <= '0;
                        r_write_done <= 1'b1;
                    end else begin
                        r_mem_addr  <= w_addr_nxt;
                        r_mem_wdata <= w_wword_nxt;
                    end
                end
                WR_DONE: begin
                    r_write_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign read_data  = r_rline;
    assign read_valid = r_read_valid;
    assign write_done = r_write_done;
    assign busy       = r_busy;
    assign mem_addr   = r_mem_addr;
    assign mem_re     = r_mem_re;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;

endmodule
